rst_req_ctrl: RTL and testbench

//   Source end of the domain reset-synchronizer path. Drives one active-low reset request into
//   NUM_DOM per-domain reset synchronizers and reads back each domain's synchronized reset as an ack.

---
 rtl/rst_req_ctrl.sv | 137 +++++++++++++
 tb/tb_rst_req_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rst_req_ctrl.sv
// Source end of the domain reset path: drives one active-low reset request to NUM_DOM
// domain synchronizers, enforces a minimum low time and confirms each domain's assert/release.
module rst_req_ctrl #(
    parameter int NUM_DOM     = 2,
    parameter int NUM_STAGES  = 2,
    parameter int HOLD_CYCLES = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Soft_RST_Req,
    input  logic [NUM_DOM-1:0] Dom_RST_Ack,
    output logic               Dom_RST_Out,
    output logic               Busy,
    output logic               Done_Pulse,
    output logic               Timeout_Err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        ASSERT_WAIT  = 3'd1,
        HOLD         = 3'd2,
        RELEASE_WAIT = 3'd3,
        DONE         = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic               req_reg;
    logic               req_edge;
    logic [NUM_DOM-1:0] ack_synced;
    logic               all_lo, all_hi;
    logic               out_reg, out_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;

    // Each ack bit arrives asynchronously and gets its own synchronizer chain.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DOM; gi++) begin : g_sync
            logic [NUM_STAGES-1:0] chain_reg;
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg <= {chain_reg[NUM_STAGES-2:0], Dom_RST_Ack[gi]};
                end
            end
            assign ack_synced[gi] = chain_reg[NUM_STAGES-1];
        end
    endgenerate

    assign all_lo   = ~|ack_synced;
    assign all_hi   = &ack_synced;
    assign req_edge = Soft_RST_Req & ~req_reg;

    // The ack condition is tested before the timeout so a coincident ack wins.
    always_comb begin
        state_next = state_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (req_edge) begin
                    state_next = ASSERT_WAIT;
                    err_next   = 1'b0;
                end
            end
            ASSERT_WAIT: begin
                if (all_lo) begin
                    state_next = HOLD;
                end else if (cnt_reg == TO_LAST) begin
                    state_next = HOLD;
                    err_next   = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_reg == HOLD_LAST) begin
                    state_next = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (all_hi) begin
                    state_next = DONE;
                end else if (cnt_reg == TO_LAST) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        out_next  = (state_next == IDLE) || (state_next == RELEASE_WAIT) || (state_next == DONE);
        busy_next = (state_next != IDLE);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= HOLD;
            cnt_reg   <= '0;
            req_reg   <= 1'b0;
            out_reg   <= 1'b0;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            req_reg   <= Soft_RST_Req;
            out_reg   <= out_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            if (state_next != state_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign Dom_RST_Out = out_reg;
    assign Busy        = busy_reg;
    assign Done_Pulse  = done_reg;
    assign Timeout_Err = err_reg;

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Directed bench for rst_req_ctrl: a small domain model echoes the reset request back as acks,
// expected values go onto a scoreboard queue and are compared when the DUT produces them.
module tb_rst_req_ctrl;

    localparam int ND = 2;
    localparam int NS = 2;
    localparam int HC = 8;
    localparam int TO = 64;
    localparam int ED = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          Soft_RST_Req = 1'b0;
    logic [ND-1:0] Dom_RST_Ack;
    logic          Dom_RST_Out, Busy, Done_Pulse, Timeout_Err;

    always #5 CLK = ~CLK;

    rst_req_ctrl #(
        .NUM_DOM    (ND),
        .NUM_STAGES (NS),
        .HOLD_CYCLES(HC),
        .TIMEOUT_CYC(TO)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Soft_RST_Req(Soft_RST_Req),
        .Dom_RST_Ack (Dom_RST_Ack),
        .Dom_RST_Out (Dom_RST_Out),
        .Busy        (Busy),
        .Done_Pulse  (Done_Pulse),
        .Timeout_Err (Timeout_Err)
    );

    // Domain model: acks follow Dom_RST_Out ED cycles late, with optional stuck bits.
    logic [ED:0] hist = '0;
    bit echo_mode = 1'b0, man_ack = 1'b0, stuck_hi1 = 1'b0, stuck_lo0 = 1'b0;

    always @(negedge CLK) hist <= {hist[ED-1:0], Dom_RST_Out};

    always_comb begin
        Dom_RST_Ack = echo_mode ? {ND{hist[ED]}} : {ND{man_ack}};
        if (stuck_hi1) Dom_RST_Ack[1] = 1'b1;
        if (stuck_lo0) Dom_RST_Ack[0] = 1'b0;
    end

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   done_cnt   = 0;
    int   idle_cyc   = 0;
    int   n;

    task automatic push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $error("FAIL scoreboard_empty: got %0d, want a queued expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                mismatched++;
                $error("FAIL %s: got %0d, want %0d", e.tag, obs, e.val);
            end
            $display("[%0t] %s observed=%0d expected=%0d", $time, e.tag, obs, e.val);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
        if (Done_Pulse === 1'b1) done_cnt++;
        if (Busy !== 1'b1) idle_cyc++;
    endtask

    // Counts sampled cycles with Dom_RST_Out low, starting with the current one.
    task automatic wait_out_high(input int limit, output int cnt);
        cnt = 0;
        while (Dom_RST_Out !== 1'b1 && cnt < limit) begin
            cnt++;
            cyc();
        end
    endtask

    task automatic wait_done(input int limit, output int cnt);
        cnt = 0;
        while (Done_Pulse !== 1'b1 && cnt < limit) begin
            cyc();
            cnt++;
        end
    endtask

    task automatic wait_timeout(input int limit, output int cnt);
        cnt = 0;
        while (Timeout_Err !== 1'b1 && cnt < limit) begin
            cyc();
            cnt++;
        end
    endtask

    task automatic pulse_req();
        Soft_RST_Req = 1'b1;
        cyc();
        Soft_RST_Req = 1'b0;
    endtask

    task automatic power_on(input string p);
        int k;
        echo_mode = 1'b0; man_ack = 1'b0; stuck_hi1 = 1'b0; stuck_lo0 = 1'b0;
        RST = 1'b0;
        repeat (3) cyc();
        push({p, "_rst_out"}, 0);     check(Dom_RST_Out);
        push({p, "_rst_busy"}, 1);    check(Busy);
        push({p, "_rst_done"}, 0);    check(Done_Pulse);
        push({p, "_rst_err"}, 0);     check(Timeout_Err);
        RST = 1'b1;
        done_cnt = 0; idle_cyc = 0;
        push({p, "_low_time"}, HC);
        wait_out_high(200, k);        check(k);
        man_ack = 1'b1;
        push({p, "_done_latency"}, NS + 1);
        wait_done(50, k);             check(k);
        push({p, "_busy_drop"}, 0);   check(idle_cyc);
        push({p, "_err"}, 0);         check(Timeout_Err);
        cyc();
        push({p, "_idle_busy"}, 0);   check(Busy);
        push({p, "_done_count"}, 1);  check(done_cnt);
        echo_mode = 1'b1;
        repeat (ED + 1) cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        power_on("por");

        // Clean soft request
        done_cnt = 0; idle_cyc = 0;
        pulse_req();
        push("soft_out_low", 0);                check(Dom_RST_Out);
        push("soft_low_time", ED + NS + 1 + HC);
        wait_out_high(300, n);                  check(n);
        push("soft_release_latency", ED + NS + 1);
        wait_done(100, n);                      check(n);
        push("soft_busy_drop", 0);              check(idle_cyc);
        push("soft_err", 0);                    check(Timeout_Err);
        cyc();
        push("soft_idle_busy", 0);              check(Busy);
        push("soft_done_count", 1);             check(done_cnt);
        repeat (ED + 1) cyc();

        // Second request during HOLD is dropped
        done_cnt = 0; idle_cyc = 0;
        pulse_req();
        repeat (8) cyc();
        pulse_req();
        push("busy_req_low_rest", ED + NS + 1 + HC - 9);
        wait_out_high(300, n);                  check(n);
        wait_done(100, n);
        repeat (6) cyc();
        push("busy_req_done_count", 1);         check(done_cnt);
        push("busy_req_idle", 0);               check(Busy);
        push("busy_req_out", 1);                check(Dom_RST_Out);

        // Ack[1] stuck high: assert-side timeout, HOLD still full length
        stuck_hi1 = 1'b1;
        done_cnt = 0; idle_cyc = 0;
        pulse_req();
        push("sh_timeout_latency", TO);
        wait_timeout(200, n);                   check(n);
        push("sh_hold_len", HC);
        wait_out_high(100, n);                  check(n);
        push("sh_release_latency", ED + NS + 1);
        wait_done(100, n);                      check(n);
        push("sh_err_sticky", 1);               check(Timeout_Err);
        cyc();
        push("sh_idle_busy", 0);                check(Busy);
        push("sh_done_count", 1);               check(done_cnt);
        stuck_hi1 = 1'b0;
        repeat (ED + 1) cyc();
        pulse_req();
        push("clean_clears_err", 0);            check(Timeout_Err);
        wait_out_high(300, n);
        wait_done(100, n);
        push("clean_err_at_done", 0);           check(Timeout_Err);
        repeat (ED + 2) cyc();

        // Ack[0] stuck low after assertion: release-side timeout
        done_cnt = 0; idle_cyc = 0;
        pulse_req();
        stuck_lo0 = 1'b1;
        push("sl_low_time", ED + NS + 1 + HC);
        wait_out_high(300, n);                  check(n);
        push("sl_release_timeout", TO);
        wait_done(200, n);                      check(n);
        push("sl_err", 1);                      check(Timeout_Err);
        cyc();
        push("sl_idle_busy", 0);                check(Busy);
        push("sl_done_count", 1);               check(done_cnt);
        stuck_lo0 = 1'b0;
        repeat (ED + 1) cyc();

        // Reset during RELEASE_WAIT with Timeout_Err set
        stuck_hi1 = 1'b1;
        pulse_req();
        push("mr_timeout_latency", TO);
        wait_timeout(200, n);                   check(n);
        wait_out_high(100, n);
        cyc();
        RST = 1'b0;
        #1;
        push("mr_out", 0);                      check(Dom_RST_Out);
        push("mr_busy", 1);                     check(Busy);
        push("mr_err", 0);                      check(Timeout_Err);
        power_on("mr_por");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
